// File: rtl/text_cursor_ctrl.sv
// Character-terminal cursor engine: turns a byte stream into text-RAM writes at a
// moving cursor, with CR/LF/backspace handling, optional ring-buffer scrolling and clear.
module text_cursor_ctrl #(
    parameter int         COLS      = 32,
    parameter int         ROWS      = 4,
    parameter int         COL_W     = 5,
    parameter int         ROW_W     = 2,
    parameter int         CRLF_MODE = 1,
    parameter int         SCROLL    = 0,
    parameter logic [7:0] BLANK     = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             clr,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_data,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] top_row,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLR_LINE = 2'd1;
    localparam logic [1:0] ST_CLR_ALL  = 2'd2;

    localparam logic [COL_W-1:0] COL_ZERO = COL_W'(32'sd0);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(32'sd1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 32'sd1);
    localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(32'sd0);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(32'sd1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 32'sd1);

    localparam logic CRLF_EN   = (CRLF_MODE != 32'sd0);
    localparam logic SCROLL_EN = (SCROLL != 32'sd0);

    // Row arithmetic wraps explicitly so ROWS need not be a power of two.
    function automatic logic [ROW_W-1:0] row_next(input logic [ROW_W-1:0] r);
        row_next = (r == ROW_LAST) ? ROW_ZERO : (r + ROW_ONE);
    endfunction

    function automatic logic [ROW_W-1:0] row_prev(input logic [ROW_W-1:0] r);
        row_prev = (r == ROW_ZERO) ? ROW_LAST : (r - ROW_ONE);
    endfunction

    logic [1:0]       state_r;
    logic [ROW_W-1:0] cur_row_r;
    logic [COL_W-1:0] cur_col_r;
    logic [ROW_W-1:0] top_row_r;
    logic [ROW_W-1:0] swp_row_r;
    logic [COL_W-1:0] swp_col_r;
    logic             wr_en_r;
    logic [ROW_W-1:0] wr_row_r;
    logic [COL_W-1:0] wr_col_r;
    logic [7:0]       wr_data_r;
    logic             in_ready_r;
    logic             busy_r;

    logic [1:0]       state_nxt_s;
    logic [ROW_W-1:0] cur_row_nxt_s;
    logic [COL_W-1:0] cur_col_nxt_s;
    logic [ROW_W-1:0] top_row_nxt_s;
    logic [ROW_W-1:0] swp_row_nxt_s;
    logic [COL_W-1:0] swp_col_nxt_s;
    logic             wr_en_nxt_s;
    logic [ROW_W-1:0] wr_row_nxt_s;
    logic [COL_W-1:0] wr_col_nxt_s;
    logic [7:0]       wr_data_nxt_s;

    logic             is_print_s;
    logic             is_lf_s;
    logic             is_cr_s;
    logic             do_nl_s;
    logic             do_cr_s;
    logic             do_bs_s;
    logic             on_bottom_s;
    logic [ROW_W-1:0] nl_row_s;
    logic [ROW_W-1:0] nl_top_s;

    assign is_print_s = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign is_lf_s    = (in_data == 8'h0A);
    assign is_cr_s    = (in_data == 8'h0D);
    assign do_nl_s    = (is_print_s && (cur_col_r == COL_LAST)) || is_lf_s || (is_cr_s && CRLF_EN);
    assign do_cr_s    = is_cr_s && !CRLF_EN;
    assign do_bs_s    = (in_data == 8'h08) && (cur_col_r != COL_ZERO);

    // On the bottom screen row a newline scrolls: the old top row becomes the new bottom.
    assign on_bottom_s = SCROLL_EN && (cur_row_r == row_prev(top_row_r));
    assign nl_row_s    = on_bottom_s ? top_row_r : row_next(cur_row_r);
    assign nl_top_s    = on_bottom_s ? row_next(top_row_r) : top_row_r;

    // Next-state logic for cursor, scroll offset, clear sweeps and the write port.
    always_comb begin
        state_nxt_s   = state_r;
        cur_row_nxt_s = cur_row_r;
        cur_col_nxt_s = cur_col_r;
        top_row_nxt_s = top_row_r;
        swp_row_nxt_s = swp_row_r;
        swp_col_nxt_s = swp_col_r;
        wr_en_nxt_s   = 1'b0;
        wr_row_nxt_s  = wr_row_r;
        wr_col_nxt_s  = wr_col_r;
        wr_data_nxt_s = wr_data_r;
        if (clr) begin
            state_nxt_s   = ST_CLR_ALL;
            cur_row_nxt_s = ROW_ZERO;
            cur_col_nxt_s = COL_ZERO;
            top_row_nxt_s = ROW_ZERO;
            swp_row_nxt_s = ROW_ZERO;
            swp_col_nxt_s = COL_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_print_s) begin
                            wr_en_nxt_s   = 1'b1;
                            wr_row_nxt_s  = cur_row_r;
                            wr_col_nxt_s  = cur_col_r;
                            wr_data_nxt_s = in_data;
                        end else if (do_bs_s) begin
                            wr_en_nxt_s   = 1'b1;
                            wr_row_nxt_s  = cur_row_r;
                            wr_col_nxt_s  = cur_col_r - COL_ONE;
                            wr_data_nxt_s = BLANK;
                        end else begin
                            wr_en_nxt_s   = 1'b0;
                        end
                        if (do_nl_s) begin
                            cur_col_nxt_s = COL_ZERO;
                            cur_row_nxt_s = nl_row_s;
                            top_row_nxt_s = nl_top_s;
                            swp_col_nxt_s = COL_ZERO;
                            state_nxt_s   = on_bottom_s ? ST_CLR_LINE : ST_IDLE;
                        end else if (is_print_s) begin
                            cur_col_nxt_s = cur_col_r + COL_ONE;
                        end else if (do_bs_s) begin
                            cur_col_nxt_s = cur_col_r - COL_ONE;
                        end else if (do_cr_s) begin
                            cur_col_nxt_s = COL_ZERO;
                        end else begin
                            cur_col_nxt_s = cur_col_r;
                        end
                    end else begin
                        wr_en_nxt_s = 1'b0;
                    end
                end
                ST_CLR_LINE: begin
                    // The cursor sits on the freshly exposed row, so it names the row to blank.
                    wr_en_nxt_s   = 1'b1;
                    wr_row_nxt_s  = cur_row_r;
                    wr_col_nxt_s  = swp_col_r;
                    wr_data_nxt_s = BLANK;
                    if (swp_col_r == COL_LAST) begin
                        swp_col_nxt_s = COL_ZERO;
                        state_nxt_s   = ST_IDLE;
                    end else begin
                        swp_col_nxt_s = swp_col_r + COL_ONE;
                    end
                end
                ST_CLR_ALL: begin
                    wr_en_nxt_s   = 1'b1;
                    wr_row_nxt_s  = swp_row_r;
                    wr_col_nxt_s  = swp_col_r;
                    wr_data_nxt_s = BLANK;
                    if (swp_col_r == COL_LAST) begin
                        swp_col_nxt_s = COL_ZERO;
                        if (swp_row_r == ROW_LAST) begin
                            swp_row_nxt_s = ROW_ZERO;
                            state_nxt_s   = ST_IDLE;
                        end else begin
                            swp_row_nxt_s = swp_row_r + ROW_ONE;
                        end
                    end else begin
                        swp_col_nxt_s = swp_col_r + COL_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; handshake flags are derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cur_row_r  <= ROW_ZERO;
            cur_col_r  <= COL_ZERO;
            top_row_r  <= ROW_ZERO;
            swp_row_r  <= ROW_ZERO;
            swp_col_r  <= COL_ZERO;
            wr_en_r    <= 1'b0;
            wr_row_r   <= ROW_ZERO;
            wr_col_r   <= COL_ZERO;
            wr_data_r  <= 8'h00;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cur_row_r  <= cur_row_nxt_s;
            cur_col_r  <= cur_col_nxt_s;
            top_row_r  <= top_row_nxt_s;
            swp_row_r  <= swp_row_nxt_s;
            swp_col_r  <= swp_col_nxt_s;
            wr_en_r    <= wr_en_nxt_s;
            wr_row_r   <= wr_row_nxt_s;
            wr_col_r   <= wr_col_nxt_s;
            wr_data_r  <= wr_data_nxt_s;
            in_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r     <= (state_nxt_s != ST_IDLE);
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign wr_en    = wr_en_r;
    assign wr_row   = wr_row_r;
    assign wr_col   = wr_col_r;
    assign wr_data  = wr_data_r;
    assign cur_row  = cur_row_r;
    assign cur_col  = cur_col_r;
    assign top_row  = top_row_r;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl: instance 0 is CRLF_MODE=0/SCROLL=0,
// instance 1 is CRLF_MODE=1/SCROLL=1; a negedge monitor checks every RAM write.
module tb_text_cursor_ctrl;

    typedef struct packed {
        logic [7:0]  dut;
        logic [31:0] cyc;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [7:0]  data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid [2];
    logic [7:0] in_data  [2];
    logic       clr      [2];
    logic       in_ready [2];
    logic       wr_en    [2];
    logic       busy     [2];
    logic [1:0] wr_row   [2];
    logic [4:0] wr_col   [2];
    logic [7:0] wr_data  [2];
    logic [1:0] cur_row  [2];
    logic [4:0] cur_col  [2];
    logic [1:0] top_row  [2];

    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];

    text_cursor_ctrl #(.COLS(32), .ROWS(4), .COL_W(5), .ROW_W(2),
                       .CRLF_MODE(0), .SCROLL(0), .BLANK(8'h20)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .clr(clr[0]), .wr_en(wr_en[0]), .wr_row(wr_row[0]),
        .wr_col(wr_col[0]), .wr_data(wr_data[0]), .cur_row(cur_row[0]),
        .cur_col(cur_col[0]), .top_row(top_row[0]), .busy(busy[0])
    );

    text_cursor_ctrl #(.COLS(32), .ROWS(4), .COL_W(5), .ROW_W(2),
                       .CRLF_MODE(1), .SCROLL(1), .BLANK(8'h20)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .clr(clr[1]), .wr_en(wr_en[1]), .wr_row(wr_row[1]),
        .wr_col(wr_col[1]), .wr_data(wr_data[1]), .cur_row(cur_row[1]),
        .cur_col(cur_col[1]), .top_row(top_row[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Writes are stamped with the cycle they appear in, so latency is checked too.
    always @(negedge clk) begin
        wr_t got;
        wr_t want;
        for (int d = 0; d < 2; d++) begin
            if (wr_en[d] === 1'b1) begin
                got = {8'(d), 32'(cyc), 8'(wr_row[d]), 8'(wr_col[d]), wr_data[d]};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %h, expected no write", got);
                end else begin
                    want = exp_q.pop_front();
                    check("write", got, want);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int d, input int stamp, input int row, input int col,
                        input logic [7:0] data);
        wr_t e;
        e.dut  = 8'(d);
        e.cyc  = 32'(stamp);
        e.row  = 8'(row);
        e.col  = 8'(col);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send(input int d, input logic [7:0] b, output int stall);
        stall = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = b;
        while (in_ready[d] !== 1'b1 && stall < 300) begin
            tick(1);
            stall++;
        end
        if (in_ready[d] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: dut%0d byte %h, in_ready still %b", d, b, in_ready[d]);
            in_valid[d] = 1'b0;
        end else begin
            tick(1);
            in_valid[d] = 1'b0;
        end
    endtask

    task automatic put(input int d, input logic [7:0] b, input int row, input int col,
                       input logic [7:0] data);
        int st;
        send(d, b, st);
        push(d, cyc, row, col, data);
    endtask

    task automatic chk_cur(input int d, input string name, input int row, input int col,
                           input int top);
        check(name, {52'd0, cur_row[d], cur_col[d], top_row[d]},
              {52'd0, 2'(row), 5'(col), 2'(top)});
    endtask

    initial begin
        int st;
        int n;
        int a;
        int c;
        logic [7:0] b;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_data[d]  = 8'h00;
            clr[d]      = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_state", {52'd0, wr_en[d], in_ready[d], busy[d], cur_row[d], cur_col[d], top_row[d]},
                  {52'd0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 2'd0});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // dut0: CRLF_MODE=0, SCROLL=0
        put(0, 8'h41, 0, 0, 8'h41);
        put(0, 8'h42, 0, 1, 8'h42);
        chk_cur(0, "ab_cursor", 0, 2, 0);
        put(0, 8'h43, 0, 2, 8'h43);
        put(0, 8'h44, 0, 3, 8'h44);
        put(0, 8'h45, 0, 4, 8'h45);
        put(0, 8'h08, 0, 4, 8'h20);
        chk_cur(0, "bs_col5", 0, 4, 0);
        for (int i = 0; i < 4; i++) put(0, 8'h08, 0, 3 - i, 8'h20);
        send(0, 8'h08, st);
        chk_cur(0, "bs_col0", 0, 0, 0);
        send(0, 8'h0A, st);
        for (int i = 0; i < 7; i++) put(0, 8'h61 + 8'(i), 1, i, 8'h61 + 8'(i));
        chk_cur(0, "at_1_7", 1, 7, 0);
        send(0, 8'h0D, st);
        chk_cur(0, "cr_only", 1, 0, 0);
        send(0, 8'h0A, st);
        chk_cur(0, "lf_after_cr", 2, 0, 0);
        send(0, 8'h01, st);
        chk_cur(0, "ignored_ctl", 2, 0, 0);
        send(0, 8'h0A, st);
        for (int i = 0; i < 32; i++) begin
            b = (i == 0) ? 8'h20 : ((i == 31) ? 8'h7E : 8'h40 + 8'(i));
            put(0, b, 3, i, b);
        end
        chk_cur(0, "wrap_no_scroll", 0, 0, 0);
        send(0, 8'h7F, st);
        send(0, 8'h1F, st);
        chk_cur(0, "ignored_7f_1f", 0, 0, 0);

        // dut1: CRLF_MODE=1, SCROLL=1
        send(1, 8'h0A, st);
        for (int i = 0; i < 7; i++) put(1, 8'h61 + 8'(i), 1, i, 8'h61 + 8'(i));
        send(1, 8'h0D, st);
        chk_cur(1, "cr_newline", 2, 0, 0);
        send(1, 8'h0A, st);
        chk_cur(1, "to_bottom", 3, 0, 0);
        send(1, 8'h0A, st);
        a = cyc;
        chk_cur(1, "scroll_cursor", 0, 0, 1);
        check("scroll_busy", {62'd0, in_ready[1], busy[1]}, {62'd0, 1'b0, 1'b1});
        for (int i = 0; i < 32; i++) push(1, a + 1 + i, 0, i, 8'h20);
        send(1, 8'h5A, st);
        push(1, cyc, 0, 0, 8'h5A);
        check("scroll_stall", 64'(st), 64'd32);
        check("scroll_idle", {62'd0, in_ready[1], busy[1]}, {62'd0, 1'b1, 1'b0});
        chk_cur(1, "after_z", 0, 1, 1);

        // scroll again, then clr in the middle of the line clear
        send(1, 8'h0A, st);
        a = cyc;
        chk_cur(1, "scroll2", 1, 0, 2);
        for (int i = 0; i < 3; i++) push(1, a + 1 + i, 1, i, 8'h20);
        tick(3);
        clr[1] = 1'b1;
        tick(1);
        clr[1] = 1'b0;
        c = cyc;
        chk_cur(1, "clr_cursor", 0, 0, 0);
        check("clr_busy", {62'd0, in_ready[1], busy[1]}, {62'd0, 1'b0, 1'b1});
        for (int i = 0; i < 9; i++) push(1, c + 1 + i, 0, i, 8'h20);
        tick(9);
        clr[1] = 1'b1;
        tick(1);
        clr[1] = 1'b0;
        c = cyc;
        for (int i = 0; i < 128; i++) push(1, c + 1 + i, i / 32, i % 32, 8'h20);
        n = 0;
        while (in_ready[1] !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        check("clr_all_len", 64'(n), 64'd128);
        chk_cur(1, "clr_all_done", 0, 0, 0);
        check("clr_all_idle", {62'd0, in_ready[1], busy[1]}, {62'd0, 1'b1, 1'b0});

        // asynchronous reset in the middle of a full clear
        clr[1] = 1'b1;
        tick(1);
        clr[1] = 1'b0;
        c = cyc;
        for (int i = 0; i < 4; i++) push(1, c + 1 + i, 0, i, 8'h20);
        tick(5);
        #1 reset = 1'b1;
        #1;
        check("async_reset", {52'd0, wr_en[1], in_ready[1], busy[1], cur_row[1], cur_col[1], top_row[1]},
              {52'd0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 2'd0});
        tick(2);
        reset = 1'b0;
        tick(2);
        put(1, 8'h51, 0, 0, 8'h51);
        chk_cur(1, "post_reset", 0, 1, 0);
        tick(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
